// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2**ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
      reg_onehot       = '0;
      reg_onehot[addr] = 1'b1;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Per-source write-back buffer: small circular FIFO of wb_req_t that also
// exports a one-hot bitmap of destination registers held in valid slots.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                push,
   input  wb_req_t             din,
   input  logic                pop,
   output wb_req_t             head,
   output logic                full,
   output logic                empty,
   output logic [NUM_REGS-1:0] occ
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   wb_req_t          mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   cnt;
   logic [PTR_W-1:0] offs;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + (PTR_W+1)'(1);
            2'b01:   cnt <= cnt - (PTR_W+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Payload storage needs no reset; slot validity comes from the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign full  = (cnt == DEPTH_C);
   assign empty = (cnt == '0);

   // A slot is live when its distance from the read pointer is below the count.
   always_comb begin
      occ  = '0;
      offs = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = PTR_W'(i) - rd_ptr;
         if ({1'b0, offs} < cnt) occ = occ | reg_onehot(mem[i].addr);
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter merging ALU (A) and load (B) results onto the regfile port.
// Optional REGFILE_WB_DROP_X0_EN: writes to register 0 are swallowed at issue.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int DEPTH  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [ADDR_W-1:0]    a_addr,
   input  logic [DATA_W-1:0]    a_data,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [ADDR_W-1:0]    b_addr,
   input  logic [DATA_W-1:0]    b_data,
   output logic                 we,
   output logic [ADDR_W-1:0]    wa,
   output logic [DATA_W-1:0]    wd,
   output logic [2**ADDR_W-1:0] pend
);

   // Round-robin pointer
   //   state | meaning
   //   SRC_A | A wins the next cycle in which both buffers hold data
   //   SRC_B | B wins the next cycle in which both buffers hold data

   src_t                rr, rr_nxt;
   wb_req_t             a_din, b_din, a_head, b_head, sel;
   logic                a_full, a_empty, b_full, b_empty;
   logic                a_push, b_push, a_pop, b_pop;
   logic                issue_we;
   logic [NUM_REGS-1:0] a_occ, b_occ, pend_c;

   assign a_din   = {a_addr, a_data};
   assign b_din   = {b_addr, b_data};
   assign a_ready = !a_full;
   assign b_ready = !b_full;
   assign a_push  = a_valid && a_ready;
   assign b_push  = b_valid && b_ready;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
      .clk   (clk),
      .reset (reset),
      .push  (a_push),
      .din   (a_din),
      .pop   (a_pop),
      .head  (a_head),
      .full  (a_full),
      .empty (a_empty),
      .occ   (a_occ)
   );

   wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
      .clk   (clk),
      .reset (reset),
      .push  (b_push),
      .din   (b_din),
      .pop   (b_pop),
      .head  (b_head),
      .full  (b_full),
      .empty (b_empty),
      .occ   (b_occ)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rr <= SRC_A;
      else        rr <= rr_nxt;
   end

   always_comb begin
      rr_nxt   = rr;
      a_pop    = 1'b0;
      b_pop    = 1'b0;
      sel      = a_head;
      issue_we = 1'b0;
      if (!a_empty && !b_empty) begin
         if (rr == SRC_A) a_pop = 1'b1;
         else             b_pop = 1'b1;
         rr_nxt = (rr == SRC_A) ? SRC_B : SRC_A;
      end else if (!a_empty) begin
         a_pop = 1'b1;
      end else if (!b_empty) begin
         b_pop = 1'b1;
      end
      if (b_pop) sel = b_head;
`ifdef REGFILE_WB_DROP_X0_EN
      issue_we = (a_pop || b_pop) && (sel.addr != '0);
`else
      issue_we = a_pop || b_pop;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we <= 1'b0;
         wa <= '0;
         wd <= '0;
      end else begin
         we <= issue_we;
         if (issue_we) begin
            wa <= sel.addr;
            wd <= sel.data;
         end
      end
   end

   always_comb begin
      pend_c = a_occ | b_occ;
      if (we) pend_c = pend_c | reg_onehot(wa);
`ifdef REGFILE_WB_DROP_X0_EN
      pend_c[0] = 1'b0;
`endif
   end

   assign pend = pend_c;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: queue-based reference of both buffers
// and the round-robin pick, compared against the DUT every cycle.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   localparam int DEPTH = 2;
`ifdef REGFILE_WB_DROP_X0_EN
   localparam bit          DROP_X0     = 1'b1;
   localparam int          X0_EXP_CNT  = 0;
   localparam logic [31:0] X0_EXP_RF0  = 32'h0;
`else
   localparam bit          DROP_X0     = 1'b0;
   localparam int          X0_EXP_CNT  = 1;
   localparam logic [31:0] X0_EXP_RF0  = 32'hFEDC_BA98;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        a_valid, b_valid, a_ready, b_ready, we;
   logic [4:0]  a_addr, b_addr, wa;
   logic [31:0] a_data, b_data, wd;
   logic [31:0] pend;

   regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .a_addr  (a_addr),
      .a_data  (a_data),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .b_addr  (b_addr),
      .b_data  (b_data),
      .we      (we),
      .wa      (wa),
      .wd      (wd),
      .pend    (pend)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   // reference model state
   wb_req_t     qa[$], qb[$];
   wb_req_t     stim_a[$], stim_b[$];
   wb_req_t     m_it;
   logic        m_we = 1'b0;
   logic [4:0]  m_wa = '0;
   logic [31:0] m_wd = '0;
   bit          rr_b = 1'b0;
   bit          acc_a, acc_b, ne_a, ne_b, pop_a, pop_b;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          we_cyc = 0;
   logic [31:0] rf [32];
   logic [4:0]  wr_log[$];
   int          cur_run = 0;
   int          max_run = 0;

   task automatic model_issue(input wb_req_t e);
      if (!(DROP_X0 && e.addr == 5'd0)) begin
         m_we = 1'b1;
         m_wa = e.addr;
         m_wd = e.data;
      end
   endtask

   function automatic logic [31:0] model_pend();
      logic [31:0] p = '0;
      foreach (qa[i]) p[qa[i].addr] = 1'b1;
      foreach (qb[i]) p[qb[i].addr] = 1'b1;
      if (m_we) p[m_wa] = 1'b1;
      if (DROP_X0) p[0] = 1'b0;
      return p;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (!reset) begin
         qa.delete(); qb.delete();
         m_we = 1'b0; m_wa = '0; m_wd = '0; rr_b = 1'b0;
      end else begin
         acc_a = a_valid && (qa.size() < DEPTH);
         acc_b = b_valid && (qb.size() < DEPTH);
         ne_a  = qa.size() != 0;
         ne_b  = qb.size() != 0;
         pop_a = ne_a && (!ne_b || !rr_b);
         pop_b = ne_b && !pop_a;
         if (ne_a && ne_b) rr_b = !rr_b;
         m_we = 1'b0;
         if (pop_a) begin m_it = qa.pop_front(); model_issue(m_it); end
         if (pop_b) begin m_it = qb.pop_front(); model_issue(m_it); end
         if (acc_a) begin qa.push_back({a_addr, a_data}); acc_cyc = cyc; end
         if (acc_b) begin qb.push_back({b_addr, b_data}); acc_cyc = cyc; end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("a_ready", a_ready, qa.size() < DEPTH);
         chk("b_ready", b_ready, qb.size() < DEPTH);
         chk("we", we, m_we);
         chk("wa", wa, m_wa);
         chk("wd", wd, m_wd);
         chk("pend", pend, model_pend());
         if (we) begin
            rf[wa] = wd;
            wr_log.push_back(wa);
            we_cyc = cyc;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
         end else begin
            cur_run = 0;
         end
      end
   end

   // source drivers: hold valid/addr/data until a handshake edge
   bit      rdy_a, rdy_b;
   wb_req_t it_a, it_b;

   initial begin
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      forever begin
         @(negedge clk); rdy_a = a_ready && reset;
         @(posedge clk); #2;
         if (a_valid && rdy_a) a_valid = 1'b0;
         if (!a_valid && stim_a.size() != 0) begin
            it_a = stim_a.pop_front();
            a_valid = 1'b1; a_addr = it_a.addr; a_data = it_a.data;
         end
      end
   end

   initial begin
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      forever begin
         @(negedge clk); rdy_b = b_ready && reset;
         @(posedge clk); #2;
         if (b_valid && rdy_b) b_valid = 1'b0;
         if (!b_valid && stim_b.size() != 0) begin
            it_b = stim_b.pop_front();
            b_valid = 1'b1; b_addr = it_b.addr; b_data = it_b.data;
         end
      end
   end

   task automatic wait_idle(input int budget);
      bit busy = 1'b1;
      for (int i = 0; i < budget && busy; i++) begin
         @(posedge clk); #3;
         busy = (stim_a.size() != 0) || (stim_b.size() != 0) || a_valid || b_valid ||
                (qa.size() != 0) || (qb.size() != 0) || m_we;
      end
      if (busy) chk("idle_timeout", busy, 1'b0);
      @(posedge clk); #3;
   endtask

   initial begin
      foreach (rf[i]) rf[i] = '0;
      #2 reset = 1'b0;
      @(posedge clk); #3;
      chk("rst_we", we, 1'b0);
      chk("rst_wa", wa, 5'd0);
      chk("rst_wd", wd, 32'd0);
      chk("rst_pend", pend, 32'd0);
      chk("rst_a_ready", a_ready, 1'b1);
      chk("rst_b_ready", b_ready, 1'b1);
      @(posedge clk); #3;
      reset = 1'b1;
      @(posedge clk); #3;

      // single write and latency
      stim_a.push_back('{addr: 5'd2, data: 32'hA5A5_A5A5});
      wait_idle(50);
      chk("single_rf2", rf[2], 32'hA5A5_A5A5);
      chk("single_latency", we_cyc + 1 - acc_cyc, 2);

      // simultaneous sources
      wr_log.delete();
      stim_a.push_back('{addr: 5'd4,  data: 32'h1432_1432});
      stim_b.push_back('{addr: 5'd12, data: 32'h1234_5678});
      wait_idle(50);
      chk("sim_count", wr_log.size(), 2);
      chk("sim_first", wr_log[0], 5'd4);
      chk("sim_second", wr_log[1], 5'd12);
      chk("sim_rf12", rf[12], 32'h1234_5678);

      // B streaming alone
      wr_log.delete(); max_run = 0;
      for (int i = 0; i < 5; i++) stim_b.push_back('{addr: 5'(8 + i), data: 32'hB000_0000 + i});
      wait_idle(100);
      chk("bp_count", wr_log.size(), 5);
      for (int i = 0; i < 5; i++) chk("bp_order", wr_log[i], 5'(8 + i));
      chk("bp_run", max_run, 5);

      // sustained contention
      wr_log.delete(); max_run = 0;
      for (int i = 0; i < 8; i++) begin
         stim_a.push_back('{addr: 5'(16 + i), data: $urandom});
         stim_b.push_back('{addr: 5'(24 + i), data: $urandom});
      end
      wait_idle(200);
      chk("cont_count", wr_log.size(), 16);
      chk("cont_run", max_run, 16);
      for (int i = 1; i < 16; i++) chk("cont_alt", wr_log[i][3] != wr_log[i-1][3], 1'b1);

      // register-0 write
      wr_log.delete();
      rf[0] = '0;
      stim_a.push_back('{addr: 5'd0, data: 32'hFEDC_BA98});
      wait_idle(50);
      chk("x0_count", wr_log.size(), X0_EXP_CNT);
      chk("x0_rf0", rf[0], X0_EXP_RF0);

      // reset with both buffers occupied
      wr_log.delete();
      stim_a.push_back('{addr: 5'd9,  data: 32'hDEAD_BEEF});
      stim_b.push_back('{addr: 5'd15, data: 32'h8888_4444});
      @(posedge clk); @(posedge clk); #3;
      chk("pre_rst_pend", pend, (32'd1 << 9) | (32'd1 << 15));
      reset = 1'b0;
      #1;
      chk("mid_rst_we", we, 1'b0);
      chk("mid_rst_pend", pend, 32'd0);
      chk("mid_rst_a_ready", a_ready, 1'b1);
      chk("mid_rst_b_ready", b_ready, 1'b1);
      qa.delete(); qb.delete();
      m_we = 1'b0; m_wa = '0; m_wd = '0; rr_b = 1'b0;
      @(posedge clk); #3;
      reset = 1'b1;
      repeat (6) @(posedge clk);
      #3;
      chk("mid_rst_no_write", wr_log.size(), 0);
      chk("mid_rst_rf9", rf[9] == 32'hDEAD_BEEF, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
